network_classifier: RTL and testbench
=====================================

NETWORK_CLASSIFIER -- requirements
Module: network_classifier

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the frame and IP statistics counters.
REQ-002 The block SHALL have parameter IP_ETHERTYPE, default 16'h0800, giving the EtherType value classified as IP.
REQ-003 CLK  in  1  clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 IN_VALID  in  1  byte strobe; IN_DATA/IN_SOP/IN_EOP are sampled only when 1; there is no backpressure.
REQ-006 IN_DATA  in  8  frame byte, destination MAC first, EtherType high byte before low byte.
REQ-007 IN_SOP  in  1  marks byte 0 of a frame.
REQ-008 IN_EOP  in  1  marks the last byte of a frame.
REQ-009 CLASS_VALID  out  1  one-cycle pulse: classification result is valid.
REQ-010 IS_IP  out  1  last classified frame carried IP_ETHERTYPE.
REQ-011 IS_RUNT  out  1  last classified frame ended before its EtherType was complete.
REQ-012 IS_VLAN  out  1  last classified frame carried one 802.1Q tag.
REQ-013 FRAME_CNT  out  CNT_W  count of classified frames.
REQ-014 IP_CNT  out  CNT_W  count of frames classified IS_IP=1.

Function
REQ-015 The FSM SHALL have states IDLE, MAC, ETH_HI, ETH_LO, VLAN_SKIP and PAYLOAD, and it SHALL advance only on accepted bytes (IN_VALID=1).
REQ-016 In IDLE, an accepted byte with IN_SOP=0 SHALL be ignored.
REQ-017 In IDLE, an accepted byte with IN_SOP=1 SHALL be byte 0, and the FSM SHALL go to MAC.
REQ-018 MAC SHALL count bytes 1..11 with an internal byte index; after byte 11 the FSM SHALL go to ETH_HI.
REQ-019 ETH_HI SHALL capture byte 12; ETH_LO SHALL capture byte 13, forming EtherType {byte12,byte13}.
REQ-020 When ETH_LO accepts its byte (and the VLAN rule does not apply), the next cycle SHALL present CLASS_VALID=1, IS_IP=(EtherType==IP_ETHERTYPE), IS_RUNT=0, IS_VLAN=0.
REQ-021 After ETH_LO, the FSM SHALL go to IDLE if that byte had IN_EOP=1, else to PAYLOAD.
REQ-022 PAYLOAD SHALL discard bytes until IN_EOP=1, then go to IDLE.
REQ-023 Runt: an accepted byte with IN_EOP=1 in MAC, ETH_HI, VLAN_SKIP, or in IDLE together with IN_SOP=1, SHALL give CLASS_VALID=1 next cycle with IS_IP=0, IS_RUNT=1, IS_VLAN=0, and the FSM SHALL go to IDLE.
REQ-024 Restart: an accepted byte with IN_SOP=1 in any non-IDLE state SHALL abandon the current frame without a CLASS_VALID and SHALL be treated as byte 0 of a new frame.
REQ-025 If the restarting SOP byte of REQ-024 also has IN_EOP=1, it SHALL be treated per REQ-023.
REQ-026 CLASS_VALID SHALL be high for exactly one cycle per classified frame; latency SHALL be 1 cycle from the deciding byte.
REQ-027 IS_IP, IS_RUNT and IS_VLAN SHALL hold their values until the next CLASS_VALID.
REQ-028 FRAME_CNT SHALL increment on every CLASS_VALID, and IP_CNT on CLASS_VALID with IS_IP=1; both SHALL saturate at all-ones and never wrap.
REQ-029 IN_EOP in PAYLOAD or IDLE SHALL produce no CLASS_VALID unless REQ-023 applies.

Reset
REQ-030 RST=1 SHALL force IDLE, clear the byte index and EtherType capture, and set every output to 0 on the next edge.
REQ-031 RST asserted mid-frame SHALL discard that frame with no CLASS_VALID; bytes after RST release without IN_SOP SHALL be ignored.

Configuration
REQ-032 Macro NETWORK_CLASSIFIER_VLAN_EN SHALL compile in single-tag 802.1Q support.
REQ-033 With NETWORK_CLASSIFIER_VLAN_EN defined, an EtherType of 16'h8100 at bytes 12-13 SHALL enter VLAN_SKIP for bytes 14-15 (TCI), then re-enter ETH_HI/ETH_LO for bytes 16-17, and the classification SHALL report IS_VLAN=1.
REQ-034 With NETWORK_CLASSIFIER_VLAN_EN defined, a second 16'h8100 at bytes 16-17 SHALL be classified IS_IP=0, IS_VLAN=1.
REQ-035 Without NETWORK_CLASSIFIER_VLAN_EN, VLAN_SKIP logic SHALL be absent, 16'h8100 SHALL classify as non-IP at byte 13, and IS_VLAN SHALL be tied 0.

Verification
REQ-036 Scenario: 60-byte frame, bytes 12-13 = 08 00, IN_VALID continuous -> one CLASS_VALID one cycle after byte 13, with IS_IP=1, FRAME_CNT=1, IP_CNT=1.
REQ-037 Scenario: frame with EtherType 86 DD, then frame with 08 06 -> two CLASS_VALIDs with IS_IP=0, FRAME_CNT=2, IP_CNT=0.
REQ-038 Scenario: 5-byte frame (EOP on byte 4), with IN_VALID gaps -> CLASS_VALID with IS_RUNT=1, IS_IP=0; then an SOP+EOP single byte -> a second runt, FRAME_CNT=2.
REQ-039 Scenario: SOP at byte 7 of a frame, then a full 08 00 frame -> exactly one CLASS_VALID with IS_IP=1; RST at byte 10 of the next frame -> no CLASS_VALID, all outputs 0.
REQ-040 Scenario: CNT_W=2, five IP frames -> FRAME_CNT=3 and IP_CNT=3 after the third frame and thereafter.
REQ-041 Scenario (VLAN_EN): bytes 12-17 = 81 00 00 05 08 00 -> CLASS_VALID after byte 17 with IS_IP=1, IS_VLAN=1; the same frame without VLAN_EN -> IS_IP=0 after byte 13.

Source files
------------

// File: rtl/network_classifier.sv
// Ethernet header classifier: flags IP / runt / 802.1Q frames and keeps saturating frame and IP counters.
// Define NETWORK_CLASSIFIER_VLAN_EN to build in single-tag 802.1Q support.
module network_classifier #(
  parameter int          CNT_W        = 8,
  parameter logic [15:0] IP_ETHERTYPE = 16'h0800
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_SOP,
  input  logic             IN_EOP,
  output logic             CLASS_VALID,
  output logic             IS_IP,
  output logic             IS_RUNT,
  output logic             IS_VLAN,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic [CNT_W-1:0] IP_CNT
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MAC       = 3'd1;
  localparam logic [2:0] ETH_HI    = 3'd2;
  localparam logic [2:0] ETH_LO    = 3'd3;
  localparam logic [2:0] PAYLOAD   = 3'd5;
`ifdef NETWORK_CLASSIFIER_VLAN_EN
  localparam logic [2:0]  VLAN_SKIP = 3'd4;
  localparam logic [15:0] VLAN_TPID = 16'h8100;
`endif

  logic [2:0]       state_reg, state_next;
  logic [3:0]       idx_reg, idx_next;
  logic [7:0]       eth_hi_reg, eth_hi_next;
  logic [15:0]      eth_type;
  logic             class_valid_reg, is_ip_reg, is_runt_reg;
  logic [CNT_W-1:0] frame_cnt_reg, ip_cnt_reg;
  logic             dec_valid, dec_ip, dec_runt;
`ifdef NETWORK_CLASSIFIER_VLAN_EN
  logic             vlan_seen_reg, vlan_seen_next;
  logic             is_vlan_reg, dec_vlan;
`endif

  assign eth_type = {eth_hi_reg, IN_DATA};

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    eth_hi_next = eth_hi_reg;
    dec_valid   = 1'b0;
    dec_ip      = 1'b0;
    dec_runt    = 1'b0;
`ifdef NETWORK_CLASSIFIER_VLAN_EN
    vlan_seen_next = vlan_seen_reg;
    dec_vlan       = 1'b0;
`endif
    if (IN_VALID) begin
      if (IN_SOP) begin
        // SOP always starts a fresh frame, abandoning any frame in progress
        idx_next = 4'd0;
`ifdef NETWORK_CLASSIFIER_VLAN_EN
        vlan_seen_next = 1'b0;
`endif
        if (IN_EOP) begin
          dec_valid  = 1'b1;
          dec_runt   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = MAC;
        end
      end else begin
        case (state_reg)
          IDLE: state_next = IDLE;
          MAC: begin
            if (IN_EOP) begin
              dec_valid  = 1'b1;
              dec_runt   = 1'b1;
              state_next = IDLE;
            end else begin
              idx_next = idx_reg + 4'd1;
              if (idx_reg == 4'd10) state_next = ETH_HI;
            end
          end
          ETH_HI: begin
            if (IN_EOP) begin
              dec_valid  = 1'b1;
              dec_runt   = 1'b1;
              state_next = IDLE;
            end else begin
              eth_hi_next = IN_DATA;
              state_next  = ETH_LO;
            end
          end
          ETH_LO: begin
`ifdef NETWORK_CLASSIFIER_VLAN_EN
            if (eth_type == VLAN_TPID && !vlan_seen_reg) begin
              // outer tag: skip the TCI and re-read the inner EtherType
              if (IN_EOP) begin
                dec_valid  = 1'b1;
                dec_runt   = 1'b1;
                state_next = IDLE;
              end else begin
                vlan_seen_next = 1'b1;
                idx_next       = 4'd0;
                state_next     = VLAN_SKIP;
              end
            end else begin
              dec_valid  = 1'b1;
              dec_ip     = (eth_type == IP_ETHERTYPE) && !(vlan_seen_reg && eth_type == VLAN_TPID);
              dec_vlan   = vlan_seen_reg;
              state_next = IN_EOP ? IDLE : PAYLOAD;
            end
`else
            dec_valid  = 1'b1;
            dec_ip     = (eth_type == IP_ETHERTYPE);
            state_next = IN_EOP ? IDLE : PAYLOAD;
`endif
          end
`ifdef NETWORK_CLASSIFIER_VLAN_EN
          VLAN_SKIP: begin
            if (IN_EOP) begin
              dec_valid  = 1'b1;
              dec_runt   = 1'b1;
              state_next = IDLE;
            end else begin
              idx_next = idx_reg + 4'd1;
              if (idx_reg[0]) state_next = ETH_HI;
            end
          end
`endif
          PAYLOAD: if (IN_EOP) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= IDLE;
      idx_reg         <= 4'd0;
      eth_hi_reg      <= 8'd0;
      class_valid_reg <= 1'b0;
      is_ip_reg       <= 1'b0;
      is_runt_reg     <= 1'b0;
      frame_cnt_reg   <= '0;
      ip_cnt_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      eth_hi_reg      <= eth_hi_next;
      class_valid_reg <= dec_valid;
      if (dec_valid) begin
        is_ip_reg   <= dec_ip;
        is_runt_reg <= dec_runt;
        if (frame_cnt_reg != '1) frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
        if (dec_ip && ip_cnt_reg != '1) ip_cnt_reg <= ip_cnt_reg + CNT_W'(1);
      end
    end
  end

`ifdef NETWORK_CLASSIFIER_VLAN_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      vlan_seen_reg <= 1'b0;
      is_vlan_reg   <= 1'b0;
    end else begin
      vlan_seen_reg <= vlan_seen_next;
      if (dec_valid) is_vlan_reg <= dec_vlan;
    end
  end
  assign IS_VLAN = is_vlan_reg;
`else
  assign IS_VLAN = 1'b0;
`endif

  assign CLASS_VALID = class_valid_reg;
  assign IS_IP       = is_ip_reg;
  assign IS_RUNT     = is_runt_reg;
  assign FRAME_CNT   = frame_cnt_reg;
  assign IP_CNT      = ip_cnt_reg;

endmodule

// File: tb/tb_network_classifier.sv
// Directed table-driven bench for network_classifier; a CNT_W=2 copy shares the stimulus to cover saturation.
module tb_network_classifier;

`ifdef NETWORK_CLASSIFIER_VLAN_EN
  localparam int VON = 1;
`else
  localparam int VON = 0;
`endif

  localparam logic [47:0] IP_HDR   = 48'h0800_4500_0054;
  localparam logic [47:0] V6_HDR   = 48'h86DD_6000_0000;
  localparam logic [47:0] ARP_HDR  = 48'h0806_0001_0800;
  localparam logic [47:0] VLAN_HDR = 48'h8100_0005_0800;
  localparam logic [47:0] QINQ_HDR = 48'h8100_0005_8100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic       class_valid, is_ip, is_runt, is_vlan;
  logic [7:0] frame_cnt, ip_cnt;
  logic       s_class_valid, s_is_ip, s_is_runt, s_is_vlan;
  logic [1:0] s_frame_cnt, s_ip_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses, s_pulses, pulse_at;

  always #5 clk = ~clk;

  network_classifier #(.CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_SOP(in_sop), .IN_EOP(in_eop),
    .CLASS_VALID(class_valid), .IS_IP(is_ip), .IS_RUNT(is_runt), .IS_VLAN(is_vlan),
    .FRAME_CNT(frame_cnt), .IP_CNT(ip_cnt)
  );

  network_classifier #(.CNT_W(2)) dut_small (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_SOP(in_sop), .IN_EOP(in_eop),
    .CLASS_VALID(s_class_valid), .IS_IP(s_is_ip), .IS_RUNT(s_is_runt), .IS_VLAN(s_is_vlan),
    .FRAME_CNT(s_frame_cnt), .IP_CNT(s_ip_cnt)
  );

  typedef struct {
    logic        rst;
    int          len;
    logic [47:0] hdr;
    logic        gaps;
    int          exp_at;
    logic        ip;
    logic        runt;
    logic        vlan;
    int          fc;
    int          ic;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic r, input int len, input logic [47:0] hdr, input logic gaps,
                              input int at, input logic ip, input logic runt, input logic vlan,
                              input int fc, input int ic);
    vec_t v;
    v.rst = r; v.len = len; v.hdr = hdr; v.gaps = gaps; v.exp_at = at;
    v.ip = ip; v.runt = runt; v.vlan = vlan; v.fc = fc; v.ic = ic;
    return v;
  endfunction

  function automatic logic [7:0] byte_at(input int i, input logic [47:0] hdr);
    if (i >= 12 && i <= 17) return hdr[8*(17-i) +: 8];
    return 8'h40 + 8'(i);
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock with the given byte; samples both DUTs #1 after the edge
  task automatic push(input logic v, input logic [7:0] d, input logic s, input logic e, input int idx);
    in_valid = v; in_data = d; in_sop = s; in_eop = e;
    @(posedge clk);
    #1;
    if (class_valid) begin
      pulses++;
      pulse_at = v ? idx : -1;
    end
    if (s_class_valid) s_pulses++;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 8'h00, 1'b0, 1'b0, -1);
  endtask

  task automatic send_frame(input int len, input logic [47:0] hdr, input logic gaps);
    pulses = 0; s_pulses = 0; pulse_at = -2;
    for (int i = 0; i < len; i++) begin
      push(1'b1, byte_at(i, hdr), i == 0, i == len - 1, i);
      // gap cycles carry junk with SOP/EOP set; they must be ignored
      if (gaps) push(1'b0, 8'($urandom), 1'b1, 1'b1, -1);
    end
    idle(3);
  endtask

  task automatic check_frame(input string tag, input int at, input logic ip, input logic runt,
                             input logic vlan, input int fc, input int ic);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " small_pulses"}, s_pulses, 1);
    check({tag, " latency_byte"}, pulse_at, at);
    check({tag, " is_ip"}, is_ip, ip);
    check({tag, " is_runt"}, is_runt, runt);
    check({tag, " is_vlan"}, is_vlan, vlan);
    check({tag, " frame_cnt"}, frame_cnt, fc);
    check({tag, " ip_cnt"}, ip_cnt, ic);
    check({tag, " small_is_ip"}, s_is_ip, ip);
    check({tag, " small_frame_cnt"}, s_frame_cnt, sat3(fc));
    check({tag, " small_ip_cnt"}, s_ip_cnt, sat3(ic));
    $display("frame %s: pulse_at=%0d ip=%0b runt=%0b vlan=%0b fc=%0d ic=%0d sfc=%0d sic=%0d",
             tag, pulse_at, is_ip, is_runt, is_vlan, frame_cnt, ip_cnt, s_frame_cnt, s_ip_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " class_valid"}, class_valid, 0);
    check({tag, " is_ip"}, is_ip, 0);
    check({tag, " is_runt"}, is_runt, 0);
    check({tag, " is_vlan"}, is_vlan, 0);
    check({tag, " frame_cnt"}, frame_cnt, 0);
    check({tag, " ip_cnt"}, ip_cnt, 0);
    check({tag, " small_frame_cnt"}, s_frame_cnt, 0);
    check({tag, " small_ip_cnt"}, s_ip_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push(1'b0, 8'h00, 1'b0, 1'b0, -1);
    rst = 1'b0;
    check_zero("reset");
    $display("reset: outputs fc=%0d ic=%0d ip=%0b", frame_cnt, ip_cnt, is_ip);
  endtask

  initial begin
    vecs[0]  = mk(1, 60, IP_HDR,   0, 13, 1, 0, 0, 1, 1);
    vecs[1]  = mk(1, 64, V6_HDR,   0, 13, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 64, ARP_HDR,  0, 13, 0, 0, 0, 2, 0);
    vecs[3]  = mk(1, 5,  IP_HDR,   1, 4,  0, 1, 0, 1, 0);
    vecs[4]  = mk(0, 1,  IP_HDR,   0, 0,  0, 1, 0, 2, 0);
    vecs[5]  = mk(0, 14, IP_HDR,   1, 13, 1, 0, 0, 3, 1);
    vecs[6]  = mk(0, 13, IP_HDR,   0, 12, 0, 1, 0, 4, 1);
    vecs[7]  = mk(0, 12, IP_HDR,   0, 11, 0, 1, 0, 5, 1);
    vecs[8]  = mk(0, 64, VLAN_HDR, 0, 13 + 4*VON, VON[0], 0, VON[0], 6, 1 + VON);
    vecs[9]  = mk(0, 64, QINQ_HDR, 0, 13 + 4*VON, 0, 0, VON[0], 7, 1 + VON);
    vecs[10] = mk(1, 20, IP_HDR,   0, 13, 1, 0, 0, 1, 1);
    vecs[11] = mk(0, 20, IP_HDR,   0, 13, 1, 0, 0, 2, 2);
    vecs[12] = mk(0, 20, IP_HDR,   0, 13, 1, 0, 0, 3, 3);
    vecs[13] = mk(0, 20, IP_HDR,   0, 13, 1, 0, 0, 4, 4);
    vecs[14] = mk(0, 20, IP_HDR,   1, 13, 1, 0, 0, 5, 5);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst) do_reset();
      send_frame(vecs[i].len, vecs[i].hdr, vecs[i].gaps);
      check_frame($sformatf("v%0d", i), vecs[i].exp_at, vecs[i].ip, vecs[i].runt,
                  vecs[i].vlan, vecs[i].fc, vecs[i].ic);
    end

    // stray bytes in IDLE, then a frame abandoned by SOP after byte 6, then a full IP frame
    do_reset();
    pulses = 0; s_pulses = 0;
    push(1'b1, 8'h55, 1'b0, 1'b1, 0);
    push(1'b1, 8'h08, 1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) push(1'b1, byte_at(i, IP_HDR), i == 0, 1'b0, i);
    check("abandon pulses", pulses, 0);
    $display("abandon: pulses=%0d fc=%0d", pulses, frame_cnt);
    send_frame(60, IP_HDR, 0);
    check_frame("restart", 13, 1, 0, 0, 1, 1);

    // reset at byte 10 of the next frame; the tail without SOP must be ignored
    pulses = 0; s_pulses = 0;
    for (int i = 0; i < 10; i++) push(1'b1, byte_at(i, IP_HDR), i == 0, 1'b0, i);
    rst = 1'b1;
    push(1'b1, byte_at(10, IP_HDR), 1'b0, 1'b0, 10);
    rst = 1'b0;
    check_zero("midrst");
    for (int i = 11; i < 60; i++) push(1'b1, byte_at(i, IP_HDR), 1'b0, i == 59, i);
    idle(3);
    check("midrst pulses", pulses, 0);
    check_zero("midrst_tail");
    $display("midrst: pulses=%0d fc=%0d ic=%0d", pulses, frame_cnt, ip_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
